// File: rtl/dds_spi_responder.sv
// dds_spi_responder: SPI-side stand-in for the DDS serial control port.
// Oversamples CS/SCLK/SDIO/IO_UPDATE in clk, decodes instruction + data
// frames, keeps a buffer bank (SPI writes) and an active bank (IO_UPDATE).
// Optional macro SDO_READBACK_EN enables the SDO read-back path; without it
// SDO is tied low and read frames are only clocked through.
module dds_spi_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              SCLK,
    input  logic              SDIO,
    output logic              SDO,
    input  logic              IO_UPDATE,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, INSTR, DATA, HOLD} state_t;

    // synchronizer stages; stage 3 only serves edge detection / alignment
    logic       cs_s1_q, cs_s2_q;
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       sdio_s1_q, sdio_s2_q, sdio_s3_q;
    logic       iou_s1_q, iou_s2_q, iou_s3_q;
    logic       sclk_rise_q, iou_rise_q;
    logic [1:0] settle_q, settle_d;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d, sdin;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              armed_q, armed_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              we;

    logic [DATA_W-1:0] bbank_q [DEPTH];
    logic [DATA_W-1:0] abank_q [DEPTH];

`ifdef SDO_READBACK_EN
    logic              sclk_fall_q;
    logic              sdo_q, sdo_d;
    logic [DATA_W-1:0] sout_q, sout_d;
`endif

    // settle counter saturates once the synchronizers hold real pin samples
    always_comb begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    end

    // 2-flop synchronizers plus registered edge events (3 clk pin-to-event)
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_s1_q <= 1'b1;  cs_s2_q <= 1'b1;
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
            sdio_s1_q <= 1'b0; sdio_s2_q <= 1'b0; sdio_s3_q <= 1'b0;
            iou_s1_q <= 1'b0;  iou_s2_q <= 1'b0;  iou_s3_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            iou_rise_q  <= 1'b0;
            settle_q    <= 2'd0;
`ifdef SDO_READBACK_EN
            sclk_fall_q <= 1'b0;
`endif
        end else begin
            cs_s1_q <= CS;         cs_s2_q <= cs_s1_q;
            sclk_s1_q <= SCLK;     sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
            sdio_s1_q <= SDIO;     sdio_s2_q <= sdio_s1_q; sdio_s3_q <= sdio_s2_q;
            iou_s1_q <= IO_UPDATE; iou_s2_q <= iou_s1_q;   iou_s3_q <= iou_s2_q;
            sclk_rise_q <= sclk_s2_q & ~sclk_s3_q;
            iou_rise_q  <= iou_s2_q & ~iou_s3_q;
            settle_q    <= settle_d;
`ifdef SDO_READBACK_EN
            sclk_fall_q <= ~sclk_s2_q & sclk_s3_q;
`endif
        end
    end

    // frame FSM: next state, shifting, commit and SDO selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        // arming needs CS seen high after reset, so a frame already running
        // across reset is parked in HOLD instead of being decoded mid-way
        armed_d     = armed_q | ((settle_q == 2'd2) & cs_s2_q);
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        we          = 1'b0;
        sdin        = {sh_q[DATA_W-2:0], sdio_s3_q};
`ifdef SDO_READBACK_EN
        sdo_d  = 1'b0;
        sout_d = sout_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (settle_q == 2'd2 && !cs_s2_q)
                    state_d = armed_q ? INSTR : HOLD;
            end
            INSTR: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                end else if (sclk_rise_q) begin
                    sh_d  = sdin;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(7)) begin
                        addr_d  = sdin[ADDR_W-1:0];
                        rd_d    = sdin[7];
                        cnt_d   = '0;
                        state_d = DATA;
`ifdef SDO_READBACK_EN
                        sout_d  = abank_q[sdin[ADDR_W-1:0]];
`endif
                    end
                end
            end
            DATA: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                end else begin
`ifdef SDO_READBACK_EN
                    sdo_d = rd_q ? sdo_q : 1'b0;
                    if (rd_q && sclk_fall_q) begin
                        sdo_d  = sout_q[DATA_W-1];
                        sout_d = {sout_q[DATA_W-2:0], 1'b0};
                    end
`endif
                    if (sclk_rise_q) begin
                        sh_d  = sdin;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W-1)) begin
                            state_d = HOLD;
`ifdef SDO_READBACK_EN
                            sdo_d   = 1'b0;
`endif
                            if (!rd_q) begin
                                we          = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = sdin;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (cs_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            armed_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef SDO_READBACK_EN
            sdo_q  <= 1'b0;
            sout_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            armed_q     <= armed_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef SDO_READBACK_EN
            sdo_q  <= sdo_d;
            sout_q <= sout_d;
`endif
        end
    end

    // register banks; the copy reads pre-write buffer values on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bbank_q[i] <= '0;
                abank_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (iou_rise_q) begin
                for (int i = 0; i < DEPTH; i++) abank_q[i] <= bbank_q[i];
            end
            if (we) bbank_q[addr_q] <= wr_data_d;
            rd_data_q <= abank_q[rd_addr];
        end
    end

    assign rd_data   = rd_data_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
`ifdef SDO_READBACK_EN
    assign SDO = sdo_q;
`else
    assign SDO = 1'b0;
`endif

endmodule
